// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage issuing data-memory requests and holding the MEM/WB register.
// Stores write exactly once while stalled; load/store counters saturate; err_rw flags read+write together.
module mem_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_re,
    input  logic             ex_we,
    input  logic [15:0]      ex_alu,
    input  logic [15:0]      ex_wdata,
    input  logic             ex_wb_en,
    input  logic [3:0]       ex_wb_reg,
    input  logic             stall,
    input  logic             flush,
    output logic [15:0]      dm_addr,
    output logic             dm_re,
    output logic             dm_we,
    output logic [15:0]      dm_wdata,
    input  logic [15:0]      dm_rdata,
    output logic             wb_valid,
    output logic             wb_en,
    output logic [3:0]       wb_reg,
    output logic [15:0]      wb_data,
    output logic             mem_ld,
    output logic [3:0]       mem_reg,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt,
    output logic             err_rw
);
    logic        m_valid, m_re, m_we, m_wb_en, m_done;
    logic [15:0] m_alu, m_wdata;
    logic [3:0]  m_wb_reg;
    logic        w_illegal;

    assign w_illegal = m_valid & m_re & m_we;
    assign dm_re     = m_valid & m_re & ~m_we;
    // m_done marks a stalled store that has already written memory
    assign dm_we     = m_valid & m_we & ~m_re & ~m_done;
    assign dm_addr   = m_alu;
    assign dm_wdata  = m_wdata;
    assign mem_ld    = dm_re;
    assign mem_reg   = m_wb_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_re     <= 1'b0;
            m_we     <= 1'b0;
            m_alu    <= '0;
            m_wdata  <= '0;
            m_wb_en  <= 1'b0;
            m_wb_reg <= '0;
            m_done   <= 1'b0;
            wb_valid <= 1'b0;
            wb_en    <= 1'b0;
            wb_reg   <= '0;
            wb_data  <= '0;
            ld_cnt   <= '0;
            st_cnt   <= '0;
            err_rw   <= 1'b0;
        end else begin
            if (flush)
                m_valid <= 1'b0;
            else if (!stall) begin
                m_valid  <= ex_valid;
                m_re     <= ex_re;
                m_we     <= ex_we;
                m_alu    <= ex_alu;
                m_wdata  <= ex_wdata;
                m_wb_en  <= ex_wb_en;
                m_wb_reg <= ex_wb_reg;
                m_done   <= 1'b0;
            end else if (dm_we)
                m_done <= 1'b1;
            if (!stall) begin
                wb_valid <= m_valid & ~w_illegal;
                wb_en    <= m_wb_en & m_valid & ~w_illegal;
                wb_reg   <= m_wb_reg;
                wb_data  <= m_re ? dm_rdata : m_alu;
            end else begin
                wb_valid <= 1'b0;
                wb_en    <= 1'b0;
            end
            if (!stall && dm_re && !(&ld_cnt))
                ld_cnt <= ld_cnt + 1'b1;
            if (dm_we && !(&st_cnt))
                st_cnt <= st_cnt + 1'b1;
            if (w_illegal)
                err_rw <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage against an instruction-level model with a memory array.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_re, ex_we, ex_wb_en, stall, flush;
    logic [15:0] ex_alu, ex_wdata, dm_rdata;
    logic [3:0]  ex_wb_reg;
    logic [15:0] dm_addr, dm_wdata, wb_data;
    logic        dm_re, dm_we, wb_valid, wb_en, mem_ld, err_rw;
    logic [3:0]  wb_reg, mem_reg;
    logic [15:0] ld_cnt, st_cnt;
    logic [15:0] s_dm_addr, s_dm_wdata, s_wb_data;
    logic        s_dm_re, s_dm_we, s_wb_valid, s_wb_en, s_mem_ld, s_err_rw;
    logic [3:0]  s_wb_reg, s_mem_reg;
    logic [1:0]  s_ld_cnt, s_st_cnt;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_re(ex_re), .ex_we(ex_we),
        .ex_alu(ex_alu), .ex_wdata(ex_wdata), .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg),
        .stall(stall), .flush(flush), .dm_addr(dm_addr), .dm_re(dm_re), .dm_we(dm_we),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .wb_valid(wb_valid), .wb_en(wb_en),
        .wb_reg(wb_reg), .wb_data(wb_data), .mem_ld(mem_ld), .mem_reg(mem_reg),
        .ld_cnt(ld_cnt), .st_cnt(st_cnt), .err_rw(err_rw)
    );

    mem_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_re(ex_re), .ex_we(ex_we),
        .ex_alu(ex_alu), .ex_wdata(ex_wdata), .ex_wb_en(ex_wb_en), .ex_wb_reg(ex_wb_reg),
        .stall(stall), .flush(flush), .dm_addr(s_dm_addr), .dm_re(s_dm_re), .dm_we(s_dm_we),
        .dm_wdata(s_dm_wdata), .dm_rdata(dm_rdata), .wb_valid(s_wb_valid), .wb_en(s_wb_en),
        .wb_reg(s_wb_reg), .wb_data(s_wb_data), .mem_ld(s_mem_ld), .mem_reg(s_mem_reg),
        .ld_cnt(s_ld_cnt), .st_cnt(s_st_cnt), .err_rw(s_err_rw)
    );

    typedef struct {
        logic        v, re, we, wbe, wrote;
        logic [15:0] alu, wd;
        logic [3:0]  rg;
    } instr_t;

    instr_t      ms;
    logic [15:0] mem [0:255];
    logic        e_wbv, e_wben;
    logic [3:0]  e_wbreg;
    logic [15:0] e_wbdata;
    int unsigned n_ld, n_st, n_ld2, n_st2;
    logic        e_err;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Instruction-level model: the instruction in MEM, memory contents, WB result and event counts
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms = '{default: '0};
            for (int i = 0; i < 256; i++) mem[i] = 16'hA500 + 16'(i);
            e_wbv = 0; e_wben = 0; e_wbreg = 0; e_wbdata = 0;
            n_ld = 0; n_st = 0; n_ld2 = 0; n_st2 = 0; e_err = 0;
        end else begin
            automatic logic is_ld  = ms.v && ms.re && !ms.we;
            automatic logic is_st  = ms.v && ms.we && !ms.re && !ms.wrote;
            automatic logic is_bad = ms.v && ms.re && ms.we;
            if (is_st) begin
                mem[ms.alu[7:0]] = ms.wd;
                if (n_st < 65535) n_st++;
                if (n_st2 < 3) n_st2++;
            end
            if (is_bad) e_err = 1;
            if (!stall) begin
                e_wbv    = ms.v && !is_bad;
                e_wben   = ms.v && ms.wbe && !is_bad;
                e_wbreg  = ms.rg;
                e_wbdata = ms.re ? mem[ms.alu[7:0]] : ms.alu;
                if (is_ld) begin
                    if (n_ld < 65535) n_ld++;
                    if (n_ld2 < 3) n_ld2++;
                end
            end else begin
                e_wbv  = 0;
                e_wben = 0;
            end
            if (flush) ms.v = 0;
            else if (!stall) ms = '{v: ex_valid, re: ex_re, we: ex_we, wbe: ex_wb_en, wrote: 1'b0,
                                    alu: ex_alu, wd: ex_wdata, rg: ex_wb_reg};
            else if (is_st) ms.wrote = 1;
        end
    end

    always @(negedge clk) dm_rdata = mem[dm_addr[7:0]];

    always @(negedge clk) begin
        automatic logic x_re = ms.v && ms.re && !ms.we;
        automatic logic x_we = ms.v && ms.we && !ms.re && !ms.wrote;
        chk("dm_re", dm_re, x_re);
        chk("dm_we", dm_we, x_we);
        chk("mem_ld", mem_ld, x_re);
        if (x_re || x_we) chk("dm_addr", dm_addr, ms.alu);
        if (x_we) chk("dm_wdata", dm_wdata, ms.wd);
        if (x_re) chk("mem_reg", mem_reg, ms.rg);
        chk("wb_valid", wb_valid, e_wbv);
        chk("wb_en", wb_en, e_wben);
        if (e_wbv) begin
            chk("wb_reg", wb_reg, e_wbreg);
            chk("wb_data", wb_data, e_wbdata);
        end
        chk("ld_cnt", ld_cnt, n_ld);
        chk("st_cnt", st_cnt, n_st);
        chk("err_rw", err_rw, e_err);
        chk("ld_cnt_w2", s_ld_cnt, n_ld2);
        chk("st_cnt_w2", s_st_cnt, n_st2);
        chk("dm_we_w2", s_dm_we, x_we);
    end

    task automatic drive(input logic v, re, we, input logic [15:0] a, d,
                         input logic wbe, input logic [3:0] rg, input logic st, fl);
        ex_valid = v; ex_re = re; ex_we = we; ex_alu = a; ex_wdata = d;
        ex_wb_en = wbe; ex_wb_reg = rg; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic st);
        drive(0, 0, 0, 16'h0, 16'h0, 0, 4'h0, st, 0);
    endtask

    initial begin
        rst_n = 1;
        ex_valid = 0; ex_re = 0; ex_we = 0; ex_alu = 0; ex_wdata = 0;
        ex_wb_en = 0; ex_wb_reg = 0; stall = 0; flush = 0;
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ld_cnt", ld_cnt, 0);
        chk("rst_err", err_rw, 0);
        // store then load back
        drive(1, 0, 1, 16'h0010, 16'hBEEF, 0, 4'h0, 0, 0);
        chk("st_dm_we", dm_we, 1);
        chk("st_addr", dm_addr, 16'h0010);
        drive(1, 1, 0, 16'h0010, 16'h0, 1, 4'h3, 0, 0);
        chk("ld_dm_we", dm_we, 0);
        chk("ld_dm_re", dm_re, 1);
        chk("ld_mem_reg", mem_reg, 3);
        chk("st_cnt1", st_cnt, 1);
        nop(0);
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_reg", wb_reg, 3);
        chk("ld_wb_data", wb_data, 16'hBEEF);
        chk("ld_cnt1", ld_cnt, 1);
        // stalled store writes once
        drive(1, 0, 1, 16'h0020, 16'h5555, 0, 4'h0, 0, 0);
        chk("sst_we0", dm_we, 1);
        nop(1);
        chk("sst_we1", dm_we, 0);
        chk("sst_wbv1", wb_valid, 0);
        chk("sst_cnt", st_cnt, 2);
        nop(1);
        chk("sst_we2", dm_we, 0);
        nop(1);
        chk("sst_we3", dm_we, 0);
        chk("sst_wbv3", wb_valid, 0);
        nop(0);
        chk("sst_wbv_rel", wb_valid, 1);
        chk("sst_wben_rel", wb_en, 0);
        nop(0);
        chk("sst_wbv_after", wb_valid, 0);
        chk("sst_cnt_final", st_cnt, 2);
        // flush kills the captured load
        drive(1, 1, 0, 16'h0010, 16'h0, 1, 4'h7, 0, 1);
        chk("fl_dm_re", dm_re, 0);
        chk("fl_mem_ld", mem_ld, 0);
        nop(0);
        chk("fl_wbv", wb_valid, 0);
        chk("fl_ld_cnt", ld_cnt, 1);
        // ALU pass-through
        drive(1, 0, 0, 16'h1234, 16'h0, 1, 4'h5, 0, 0);
        chk("alu_mem_ld", mem_ld, 0);
        nop(0);
        chk("alu_wb_data", wb_data, 16'h1234);
        chk("alu_wb_en", wb_en, 1);
        chk("alu_wb_reg", wb_reg, 5);
        // illegal read+write, then a legal load
        drive(1, 1, 1, 16'h0030, 16'h7777, 1, 4'h9, 0, 0);
        chk("ill_dm_re", dm_re, 0);
        chk("ill_dm_we", dm_we, 0);
        drive(1, 1, 0, 16'h0020, 16'h0, 1, 4'h4, 0, 0);
        chk("ill_wbv", wb_valid, 0);
        chk("ill_err", err_rw, 1);
        nop(0);
        chk("ill_ld_data", wb_data, 16'h5555);
        chk("ill_err_sticky", err_rw, 1);
        chk("ill_ld_cnt", ld_cnt, 2);
        // flush wins over stall
        drive(1, 0, 1, 16'h0050, 16'h1111, 0, 4'h0, 1, 1);
        chk("fls_dm_we", dm_we, 0);
        nop(0);
        chk("fls_st_cnt", st_cnt, 2);
        // five loads, the first held two stalled cycles
        drive(1, 1, 0, 16'h0010, 16'h0, 1, 4'h1, 0, 0);
        nop(1);
        nop(1);
        chk("sld_cnt_held", ld_cnt, 2);
        for (int i = 1; i <= 4; i++) drive(1, 1, 0, 16'h0010 + 16'(i), 16'h0, 1, 4'h2, 0, 0);
        nop(0);
        chk("sat_ld_cnt", ld_cnt, 7);
        chk("sat_ld_cnt_w2", s_ld_cnt, 3);
        chk("sat_ld_data", wb_data, 16'hA514);
        drive(1, 0, 1, 16'h0060, 16'h0001, 0, 4'h0, 0, 0);
        drive(1, 0, 1, 16'h0061, 16'h0002, 0, 4'h0, 0, 0);
        nop(0);
        chk("sat_st_cnt", st_cnt, 4);
        chk("sat_st_cnt_w2", s_st_cnt, 3);
        // reset in the middle of a store
        drive(1, 0, 1, 16'h0040, 16'hDEAD, 0, 4'h0, 0, 0);
        chk("mrs_we_before", dm_we, 1);
        ex_valid = 0; ex_we = 0;
        #3 rst_n = 0;
        #1;
        chk("mrs_dm_we", dm_we, 0);
        chk("mrs_dm_re", dm_re, 0);
        chk("mrs_ld_cnt", ld_cnt, 0);
        chk("mrs_st_cnt", st_cnt, 0);
        chk("mrs_ld_cnt_w2", s_ld_cnt, 0);
        chk("mrs_err", err_rw, 0);
        chk("mrs_wbv", wb_valid, 0);
        @(posedge clk);
        #1 rst_n = 1;
        drive(1, 1, 0, 16'h0040, 16'h0, 1, 4'h6, 0, 0);
        chk("post_dm_re", dm_re, 1);
        nop(0);
        chk("post_wbv", wb_valid, 1);
        chk("post_wb_data", wb_data, 16'hA540);
        chk("post_ld_cnt", ld_cnt, 1);
        chk("post_st_cnt", st_cnt, 0);
        nop(0);
        nop(0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
